jtdd_rom_arb: RTL and testbench

JTDD_ROM_ARB -- requirements
Module: jtdd_rom_arb

---
 rtl/jtdd_rom_arb_if.sv | 40 ++++
 rtl/jtdd_rom_arb.sv | 167 ++++++++++++++++
 tb/tb_jtdd_rom_arb.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/jtdd_rom_arb_if.sv
// ROM arbiter bus bundle.
// Groups the three requester ports (scr, chr, obj) and the shared
// memory-controller port of jtdd_rom_arb.
//   x_addr / x_cs        : requester word address and request enable
//   x_data / x_ok        : last fetched word, valid for the current address
//   mem_addr / mem_req   : shared ROM address and fetch request
//   mem_data / mem_ok    : returned word and its one-cycle valid pulse
// Modport slave is taken by the arbiter; modport master by whatever
// drives the requests and models the memory.
interface jtdd_rom_arb_if #(
    parameter int AW = 17,
    parameter int MW = 20
);
    logic [AW-1:0] scr_addr, chr_addr, obj_addr;
    logic          scr_cs,   chr_cs,   obj_cs;
    logic [15:0]   scr_data, chr_data, obj_data;
    logic          scr_ok,   chr_ok,   obj_ok;
    logic [MW-1:0] mem_addr;
    logic          mem_req;
    logic [15:0]   mem_data;
    logic          mem_ok;

    modport slave (
        input  scr_addr, chr_addr, obj_addr,
        input  scr_cs,   chr_cs,   obj_cs,
        output scr_data, chr_data, obj_data,
        output scr_ok,   chr_ok,   obj_ok,
        output mem_addr, mem_req,
        input  mem_data, mem_ok
    );

    modport master (
        output scr_addr, chr_addr, obj_addr,
        output scr_cs,   chr_cs,   obj_cs,
        input  scr_data, chr_data, obj_data,
        input  scr_ok,   chr_ok,   obj_ok,
        input  mem_addr, mem_req,
        output mem_data, mem_ok
    );
endinterface

// File: rtl/jtdd_rom_arb.sv
// Three-way ROM fetch arbiter with a one-word cache per requester.
// Each requester (scr, chr, obj) keeps its last fetched word and the
// address it belongs to; x_ok is high while the requested address matches
// that cached word. A miss issues one fetch at a time on the shared memory
// port, with a per-requester base offset added to the address.
//
// Ports:
//   clk  : clock, all state changes on posedge
//   rst  : asynchronous active-high reset
//   bus  : jtdd_rom_arb_if.slave (requester and memory signals)
//
// Build option:
//   JTDD_ROMARB_RR_EN  defined   -> round-robin arbitration, last served
//                                   requester gets lowest priority
//                      undefined -> fixed priority scr > chr > obj
//
// state   | meaning
// ST_IDLE | no fetch in flight; grant a pending requester if any
// ST_WAIT | fetch issued, mem_addr/mem_req held until mem_ok
module jtdd_rom_arb #(
    parameter int            AW         = 17,
    parameter int            MW         = 20,
    parameter logic [MW-1:0] SCR_OFFSET = '0,
    parameter logic [MW-1:0] CHR_OFFSET = 20'h20000,
    parameter logic [MW-1:0] OBJ_OFFSET = 20'h40000
) (
    input  logic           clk,
    input  logic           rst,
    jtdd_rom_arb_if.slave  bus
);

    typedef enum logic {ST_IDLE, ST_WAIT} state_t;

    state_t        state;
    logic [1:0]    sel;
    logic [AW-1:0] lat_addr;
    logic [MW-1:0] mem_addr_r;
    logic          mem_req_r;

    logic [AW-1:0] last_addr [3];
    logic [15:0]   data_r    [3];
    logic [2:0]    valid;

    logic [AW-1:0] addr_in [3];
    logic [2:0]    cs_in;
    logic [2:0]    ok_v;
    logic [2:0]    pend;
    logic [1:0]    gnt;
    logic [AW-1:0] gnt_addr;
    logic [MW-1:0] gnt_off;

    assign addr_in[0] = bus.scr_addr;
    assign addr_in[1] = bus.chr_addr;
    assign addr_in[2] = bus.obj_addr;
    assign cs_in      = {bus.obj_cs, bus.chr_cs, bus.scr_cs};

    always_comb begin
        ok_v = '0;
        pend = '0;
        for (int i = 0; i < 3; i++) begin
            ok_v[i] = cs_in[i] && valid[i] && (addr_in[i] == last_addr[i]);
            pend[i] = cs_in[i] && !ok_v[i];
        end
    end

`ifdef JTDD_ROMARB_RR_EN
    // rr_ptr names the requester with highest priority this round
    logic [1:0] rr_ptr;
    logic [1:0] rr_p1;
    logic [1:0] rr_p2;

    function automatic logic [1:0] nxt(input logic [1:0] i);
        return (i == 2'd2) ? 2'd0 : i + 2'd1;
    endfunction

    always_comb begin
        rr_p1 = nxt(rr_ptr);
        rr_p2 = nxt(rr_p1);
        gnt   = rr_p2;
        if (pend[rr_ptr])
            gnt = rr_ptr;
        else if (pend[rr_p1])
            gnt = rr_p1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rr_ptr <= 2'd0;
        else if (state == ST_IDLE && |pend)
            rr_ptr <= nxt(gnt);
    end
`else
    always_comb begin
        gnt = 2'd2;
        if (pend[0])
            gnt = 2'd0;
        else if (pend[1])
            gnt = 2'd1;
    end
`endif

    always_comb begin
        gnt_addr = addr_in[2];
        gnt_off  = OBJ_OFFSET;
        case (gnt)
            2'd0: begin
                gnt_addr = addr_in[0];
                gnt_off  = SCR_OFFSET;
            end
            2'd1: begin
                gnt_addr = addr_in[1];
                gnt_off  = CHR_OFFSET;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            sel        <= 2'd0;
            lat_addr   <= '0;
            mem_addr_r <= '0;
            mem_req_r  <= 1'b0;
            valid      <= '0;
            for (int i = 0; i < 3; i++) begin
                last_addr[i] <= '0;
                data_r[i]    <= '0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    // mem_ok here is stale (e.g. a fetch abandoned by reset)
                    if (|pend) begin
                        sel        <= gnt;
                        lat_addr   <= gnt_addr;
                        mem_addr_r <= MW'(gnt_addr) + gnt_off;
                        mem_req_r  <= 1'b1;
                        state      <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // stored under the latched address even if the
                    // requester moved on; its ok then stays low
                    if (bus.mem_ok) begin
                        data_r[sel]    <= bus.mem_data;
                        last_addr[sel] <= lat_addr;
                        valid[sel]     <= 1'b1;
                        mem_req_r      <= 1'b0;
                        state          <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.mem_addr = mem_addr_r;
    assign bus.mem_req  = mem_req_r;
    assign bus.scr_data = data_r[0];
    assign bus.chr_data = data_r[1];
    assign bus.obj_data = data_r[2];
    assign bus.scr_ok   = ok_v[0];
    assign bus.chr_ok   = ok_v[1];
    assign bus.obj_ok   = ok_v[2];

endmodule

// File: tb/tb_jtdd_rom_arb.sv
module tb_jtdd_rom_arb;

    logic clk = 1'b0;
    logic rst = 1'b1;

    jtdd_rom_arb_if #(.AW(17), .MW(20)) bus ();

    jtdd_rom_arb dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic [15:0] data;
    } ok_t;

    logic [19:0] fetch_q [$];
    ok_t         ok_q    [$];

    int checks    = 0;
    int failures  = 0;
    int fetch_cnt = 0;
    int stray_req = 0;
    int resp_delay = 3;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] mem_fn(input logic [19:0] a);
        if (a == 20'h00123)
            return 16'hBEEF;
        return a[15:0] ^ 16'h5A5A;
    endfunction

    function automatic logic [15:0] data_of(input int i);
        case (i)
            0:       return bus.scr_data;
            1:       return bus.chr_data;
            default: return bus.obj_data;
        endcase
    endfunction

    // memory model: answers each new mem_req after resp_delay cycles
    initial begin
        int          stray_done;
        logic [19:0] a;
        stray_done   = 0;
        bus.mem_ok   = 1'b0;
        bus.mem_data = 16'h0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.mem_req && !rst) begin
                a = bus.mem_addr;
                repeat (resp_delay - 1) @(posedge clk);
                #1;
                bus.mem_ok   = 1'b1;
                bus.mem_data = mem_fn(a);
                @(posedge clk);
                #1;
                bus.mem_ok   = 1'b0;
            end else if (stray_req != stray_done) begin
                stray_done   = stray_req;
                bus.mem_ok   = 1'b1;
                bus.mem_data = 16'h1234;
                @(posedge clk);
                #1;
                bus.mem_ok   = 1'b0;
            end
        end
    end

    // fetch monitor
    logic        req_d = 1'b0;
    logic [19:0] cur_addr = '0;
    always @(negedge clk) begin
        logic [19:0] e;
        if (bus.mem_req && !req_d) begin
            fetch_cnt++;
            if (fetch_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_fetch: got %0h expected none", bus.mem_addr);
            end else begin
                e = fetch_q.pop_front();
                check("mem_addr", 64'(bus.mem_addr), 64'(e));
            end
            cur_addr <= bus.mem_addr;
        end else if (bus.mem_req && req_d) begin
            check("mem_addr_hold", 64'(bus.mem_addr), 64'(cur_addr));
        end
        req_d <= bus.mem_req;
    end

    // ok monitor
    logic [2:0] ok_d = 3'b000;
    always @(negedge clk) begin
        logic [2:0] oks;
        ok_t        e;
        oks = {bus.obj_ok, bus.chr_ok, bus.scr_ok};
        for (int i = 0; i < 3; i++) begin
            if (oks[i] && !ok_d[i]) begin
                if (ok_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_ok: got requester %0d expected none", i);
                end else begin
                    e = ok_q.pop_front();
                    check("ok_requester", 64'(i), 64'(e.idx));
                    check("ok_data", 64'(data_of(i)), 64'(e.data));
                end
            end
        end
        ok_d <= oks;
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_rise(input string name);
        int n;
        n = 0;
        while (!bus.mem_req && n < 50) begin
            cyc(1);
            n++;
        end
        check({name, "_req_rise"}, 64'(bus.mem_req), 64'd1);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((fetch_q.size() != 0 || ok_q.size() != 0 || bus.mem_req) && n < 200) begin
            cyc(1);
            n++;
        end
        check({name, "_drain"}, 64'(fetch_q.size() + ok_q.size()), 64'd0);
        fetch_q.delete();
        ok_q.delete();
        cyc(2);
    endtask

    task automatic do_reset();
        bus.scr_cs = 1'b0;
        bus.chr_cs = 1'b0;
        bus.obj_cs = 1'b0;
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        cyc(1);
    endtask

    initial begin
        int n;
        int fc;
        bus.scr_addr = '0;
        bus.chr_addr = '0;
        bus.obj_addr = '0;
        bus.scr_cs   = 1'b0;
        bus.chr_cs   = 1'b0;
        bus.obj_cs   = 1'b0;
        rst = 1'b1;
        cyc(2);
        check("rst_mem_req", 64'(bus.mem_req), 64'd0);
        check("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
        check("rst_ok", 64'({bus.scr_ok, bus.chr_ok, bus.obj_ok}), 64'd0);
        check("rst_data", 64'({bus.scr_data, bus.chr_data, bus.obj_data}), 64'd0);
        rst = 1'b0;
        cyc(1);

        // single fetch, three-cycle memory
        fetch_q.push_back(20'h00123);
        ok_q.push_back('{0, 16'hBEEF});
        bus.scr_addr = 17'h00123;
        bus.scr_cs   = 1'b1;
        wait_rise("t31");
        n = 0;
        do begin
            @(posedge clk);
            n++;
            #1;
        end while (bus.mem_req && n < 20);
        check("t31_req_cycles", 64'(n), 64'd3);
        check("t31_scr_ok", 64'(bus.scr_ok), 64'd1);
        check("t31_scr_data", 64'(bus.scr_data), 64'hBEEF);
        wait_idle("t31");

        // chr offset, then same address again hits the cache
        fetch_q.push_back(20'h20010);
        ok_q.push_back('{1, 16'h5A4A});
        bus.chr_addr = 17'h00010;
        bus.chr_cs   = 1'b1;
        wait_idle("t32");
        fc = fetch_cnt;
        bus.chr_addr = 17'h00010;
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            check("t32_chr_ok_held", 64'(bus.chr_ok), 64'd1);
        end
        check("t32_no_refetch", 64'(fetch_cnt), 64'(fc));
        check("t32_chr_data", 64'(bus.chr_data), 64'h5A4A);

        // mem_ok with no fetch in flight is ignored
        stray_req++;
        cyc(4);
        check("stray_scr_data", 64'(bus.scr_data), 64'hBEEF);
        check("stray_chr_data", 64'(bus.chr_data), 64'h5A4A);
        check("stray_obj_data", 64'(bus.obj_data), 64'h0);
        check("stray_mem_req", 64'(bus.mem_req), 64'd0);

        // all three requesting together from reset
        do_reset();
        fetch_q.push_back(20'h00005);
        fetch_q.push_back(20'h20006);
        fetch_q.push_back(20'h40007);
        ok_q.push_back('{0, 16'h5A5F});
        ok_q.push_back('{1, 16'h5A5C});
        ok_q.push_back('{2, 16'h5A5D});
        bus.scr_addr = 17'h00005;
        bus.chr_addr = 17'h00006;
        bus.obj_addr = 17'h00007;
        bus.scr_cs   = 1'b1;
        bus.chr_cs   = 1'b1;
        bus.obj_cs   = 1'b1;
        wait_idle("t33a");

        // scr re-requests while its first fetch is in flight
        do_reset();
        fetch_q.push_back(20'h00008);
        bus.scr_addr = 17'h00008;
        bus.chr_addr = 17'h00009;
        bus.obj_addr = 17'h0000A;
        bus.scr_cs   = 1'b1;
        bus.chr_cs   = 1'b1;
        bus.obj_cs   = 1'b1;
        wait_rise("t33b");
        bus.scr_addr = 17'h0000B;
`ifdef JTDD_ROMARB_RR_EN
        fetch_q.push_back(20'h20009);
        fetch_q.push_back(20'h4000A);
        fetch_q.push_back(20'h0000B);
        ok_q.push_back('{1, 16'h5A53});
        ok_q.push_back('{2, 16'h5A50});
        ok_q.push_back('{0, 16'h5A51});
`else
        fetch_q.push_back(20'h0000B);
        fetch_q.push_back(20'h20009);
        fetch_q.push_back(20'h4000A);
        ok_q.push_back('{0, 16'h5A51});
        ok_q.push_back('{1, 16'h5A53});
        ok_q.push_back('{2, 16'h5A50});
`endif
        wait_idle("t33b");

        // address change during WAIT
        do_reset();
        fetch_q.push_back(20'h00001);
        bus.scr_addr = 17'h00001;
        bus.scr_cs   = 1'b1;
        wait_rise("t34");
        bus.scr_addr = 17'h00002;
        fetch_q.push_back(20'h00002);
        ok_q.push_back('{0, 16'h5A58});
        n = 0;
        while (bus.mem_req && n < 20) begin
            cyc(1);
            n++;
        end
        check("t34_req_drop", 64'(bus.mem_req), 64'd0);
        check("t34_scr_ok_low", 64'(bus.scr_ok), 64'd0);
        check("t34_stored_data", 64'(bus.scr_data), 64'h5A5B);
        cyc(1);
        check("t34_refetch_req", 64'(bus.mem_req), 64'd1);
        check("t34_refetch_addr", 64'(bus.mem_addr), 64'h00002);
        wait_idle("t34");

        // reset in the middle of a fetch, late mem_ok ignored
        do_reset();
        fetch_q.push_back(20'h00030);
        bus.scr_addr = 17'h00030;
        bus.scr_cs   = 1'b1;
        wait_rise("t35");
        cyc(1);
        rst = 1'b1;
        bus.scr_cs = 1'b0;
        #1;
        check("t35_async_req", 64'(bus.mem_req), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(4);
        check("t35_mem_req", 64'(bus.mem_req), 64'd0);
        check("t35_mem_addr", 64'(bus.mem_addr), 64'd0);
        check("t35_scr_data", 64'(bus.scr_data), 64'd0);
        check("t35_ok", 64'({bus.scr_ok, bus.chr_ok, bus.obj_ok}), 64'd0);
        fetch_q.push_back(20'h00030);
        ok_q.push_back('{0, 16'h5A6A});
        bus.scr_cs = 1'b1;
        wait_idle("t35");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
